// File: rtl/mem_port_arbiter.sv
// Shares the single-port instruction/data BRAM between fetch and the load/store unit.
// Data accesses have priority over fetch, but a streak limit stops fetch from starving.
// Stores are lane-aligned on the way in; load results are extracted and extended on the way out.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned MAX_DM_STREAK = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // fetch port
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              if_valid_o,
    // data port
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [2:0]        dm_funct3_i,
    input  logic [31:0]       dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic [31:0]       dm_rdata_o,
    output logic              dm_valid_o,
    output logic              dm_err_o,
    // memory port
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int unsigned StreakW =
        (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DM_STREAK);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                grant_dm_q, grant_dm_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                mem_en_q, mem_en_d;
    logic [3:0]          mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                err_q, err_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic                is_store_q, is_store_d;

    // Decode of the pending data request
    logic                dec_err;
    logic [3:0]          dec_we;
    logic [31:0]         dec_wdata;

    // Load formatting
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [31:0]         load_data;
    logic                in_resp;

    // Address bits outside the memory window alias; fetch byte offset is ignored.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                                dm_addr_i[31:ADDR_W+2]};

    // Classify the data request: legality, byte enables and lane-replicated store data.
    always_comb begin
        dec_err   = 1'b0;
        dec_we    = 4'b0000;
        dec_wdata = 32'h0;
        if (dm_we_i) begin
            unique case (dm_funct3_i)
                3'd0: begin
                    dec_we    = 4'b0001 << dm_addr_i[1:0];
                    dec_wdata = {4{dm_wdata_i[7:0]}};
                end
                3'd1: begin
                    dec_err   = dm_addr_i[0];
                    dec_we    = dm_addr_i[1] ? 4'b1100 : 4'b0011;
                    dec_wdata = {2{dm_wdata_i[15:0]}};
                end
                3'd2: begin
                    dec_err   = (dm_addr_i[1:0] != 2'b00);
                    dec_we    = 4'b1111;
                    dec_wdata = dm_wdata_i;
                end
                default: dec_err = 1'b1;
            endcase
        end else begin
            unique case (dm_funct3_i)
                3'd0, 3'd4: dec_err = 1'b0;
                3'd1, 3'd5: dec_err = dm_addr_i[0];
                3'd2:       dec_err = (dm_addr_i[1:0] != 2'b00);
                default:    dec_err = 1'b1;
            endcase
        end
    end

    // Next-state: grant selection in IDLE, fixed one-cycle ACCESS and RESP.
    always_comb begin
        state_d     = state_q;
        grant_dm_d  = grant_dm_q;
        streak_d    = streak_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 4'b0000;
        mem_wdata_d = 32'h0;
        mem_addr_d  = mem_addr_q;
        err_d       = err_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        is_store_d  = is_store_q;
        unique case (state_q)
            StIdle: begin
                if (dm_req_i && !(if_req_i && (streak_q == StreakMax))) begin
                    state_d    = StAccess;
                    grant_dm_d = 1'b1;
                    if (!if_req_i) begin
                        streak_d = '0;
                    end else if (streak_q != StreakMax) begin
                        streak_d = streak_q + 1'b1;
                    end
                    mem_addr_d  = dm_addr_i[ADDR_W+1:2];
                    err_d       = dec_err;
                    funct3_d    = dm_funct3_i;
                    off_d       = dm_addr_i[1:0];
                    is_store_d  = dm_we_i;
                    // An illegal request never touches memory.
                    mem_en_d    = !dec_err;
                    mem_we_d    = dec_err ? 4'b0000 : dec_we;
                    mem_wdata_d = dec_err ? 32'h0 : dec_wdata;
                end else if (if_req_i) begin
                    state_d    = StAccess;
                    grant_dm_d = 1'b0;
                    streak_d   = '0;
                    mem_addr_d = if_addr_i[ADDR_W+1:2];
                    err_d      = 1'b0;
                    is_store_d = 1'b0;
                    mem_en_d   = 1'b1;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State and access registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            grant_dm_q  <= 1'b0;
            streak_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            err_q       <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            is_store_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_dm_q  <= grant_dm_d;
            streak_q    <= streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            is_store_q  <= is_store_d;
        end
    end

    // Extract and extend the addressed lane from the returned word.
    always_comb begin
        byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        unique case (funct3_q)
            3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    load_data = {24'h0, byte_sel};
            3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
            3'd5:    load_data = {16'h0, half_sel};
            3'd2:    load_data = mem_rdata_i;
            default: load_data = 32'h0;
        endcase
    end

    // Response outputs are zero whenever their valid is low.
    always_comb begin
        in_resp    = (state_q == StResp);
        if_valid_o = in_resp && !grant_dm_q;
        dm_valid_o = in_resp && grant_dm_q;
        dm_err_o   = dm_valid_o && err_q;
        if_rdata_o = if_valid_o ? mem_rdata_i : 32'h0;
        dm_rdata_o = (dm_valid_o && !err_q && !is_store_q) ? load_data : 32'h0;
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, stores, loads, errors, arbitration.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              dm_req;
    logic              dm_we;
    logic [2:0]        dm_funct3;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_valid;
    logic              dm_err;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .ADDR_W        (ADDR_W),
        .MAX_DM_STREAK (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata),
        .if_valid_o  (if_valid),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_funct3_i (dm_funct3),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_rdata_o  (dm_rdata),
        .dm_valid_o  (dm_valid),
        .dm_err_o    (dm_err),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One data transaction from IDLE: checks ACCESS, RESP and the return to IDLE.
    task automatic dm_txn(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic exp_en,
                          input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rd, input logic exp_err);
        logic [ADDR_W-1:0] exp_addr;
        exp_addr  = addr[ADDR_W+1:2];
        dm_req    = 1'b1;
        dm_we     = we;
        dm_funct3 = f3;
        dm_addr   = addr;
        dm_wdata  = wdata;
        mem_rdata = rdata;
        step();
        chk({tag, ".en"}, 32'(mem_en), 32'(exp_en));
        if (exp_en) begin
            chk({tag, ".we"}, 32'(mem_we), 32'(exp_we));
            chk({tag, ".addr"}, 32'(mem_addr), 32'(exp_addr));
            if (we) chk({tag, ".wdata"}, mem_wdata, exp_wdata);
        end
        step();
        chk({tag, ".valid"}, 32'(dm_valid), 32'd1);
        chk({tag, ".err"}, 32'(dm_err), 32'(exp_err));
        chk({tag, ".rdata"}, dm_rdata, exp_rd);
        dm_req = 1'b0;
        step();
        chk({tag, ".idle"}, 32'({dm_valid, mem_en}), 32'd0);
    endtask

    initial begin
        logic seen;
        logic got_dm;
        logic exp_dm [6];
        exp_dm = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0104;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_funct3 = 3'd0;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        mem_rdata = 32'h0010_0093;

        // Reset held three cycles with a fetch pending
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.mem_en", 32'(mem_en), 32'd0);
            chk("rst.if_valid", 32'(if_valid), 32'd0);
        end
        chk("rst.outs", {dm_valid, dm_err, mem_we, 26'h0}, 32'h0);
        chk("rst.if_rdata", if_rdata, 32'h0);
        chk("rst.dm_rdata", dm_rdata, 32'h0);
        chk("rst.mem_addr", 32'(mem_addr), 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        // First edge after release grants the fetch; ACCESS follows
        step();
        chk("fetch.en", 32'(mem_en), 32'd1);
        chk("fetch.we", 32'(mem_we), 32'd0);
        chk("fetch.addr", 32'(mem_addr), 32'h041);
        chk("fetch.early", 32'(if_valid), 32'd0);
        step();
        chk("fetch.valid", 32'(if_valid), 32'd1);
        chk("fetch.rdata", if_rdata, 32'h0010_0093);
        chk("fetch.dmv", 32'(dm_valid), 32'd0);
        if_req = 1'b0;
        step();
        chk("fetch.drop", {31'h0, if_valid}, 32'd0);
        chk("fetch.rdata0", if_rdata, 32'h0);

        // Stores
        dm_txn("sb", 1'b1, 3'd0, 32'h203, 32'h0000_00AB, 32'hFFFF_FFFF,
               1'b1, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0);
        dm_txn("sh", 1'b1, 3'd1, 32'h202, 32'h0000_1234, 32'hFFFF_FFFF,
               1'b1, 4'b1100, 32'h1234_1234, 32'h0, 1'b0);
        dm_txn("sb0", 1'b1, 3'd0, 32'h200, 32'h0000_005A, 32'hFFFF_FFFF,
               1'b1, 4'b0001, 32'h5A5A_5A5A, 32'h0, 1'b0);
        dm_txn("sw", 1'b1, 3'd2, 32'h200, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
               1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);

        // Loads from a word holding 0x80FF7F01
        dm_txn("lb1", 1'b0, 3'd0, 32'h301, 32'h0, 32'h80FF_7F01,
               1'b1, 4'b0000, 32'h0, 32'h0000_007F, 1'b0);
        dm_txn("lb3", 1'b0, 3'd0, 32'h303, 32'h0, 32'h80FF_7F01,
               1'b1, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0);
        dm_txn("lbu3", 1'b0, 3'd4, 32'h303, 32'h0, 32'h80FF_7F01,
               1'b1, 4'b0000, 32'h0, 32'h0000_0080, 1'b0);
        dm_txn("lh2", 1'b0, 3'd1, 32'h302, 32'h0, 32'h80FF_7F01,
               1'b1, 4'b0000, 32'h0, 32'hFFFF_80FF, 1'b0);
        dm_txn("lhu2", 1'b0, 3'd5, 32'h302, 32'h0, 32'h80FF_7F01,
               1'b1, 4'b0000, 32'h0, 32'h0000_80FF, 1'b0);
        dm_txn("lh0", 1'b0, 3'd1, 32'h300, 32'h0, 32'h80FF_7F01,
               1'b1, 4'b0000, 32'h0, 32'h0000_7F01, 1'b0);
        dm_txn("lw", 1'b0, 3'd2, 32'h300, 32'h0, 32'h80FF_7F01,
               1'b1, 4'b0000, 32'h0, 32'h80FF_7F01, 1'b0);
        // High address bits alias onto the same word
        dm_txn("alias", 1'b0, 3'd2, 32'hFFFF_C300, 32'h0, 32'h1357_9BDF,
               1'b1, 4'b0000, 32'h0, 32'h1357_9BDF, 1'b0);

        // Errors: no memory access, error response with zero data
        dm_txn("e_lw", 1'b0, 3'd2, 32'h302, 32'h0, 32'h80FF_7F01,
               1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        dm_txn("e_sh", 1'b1, 3'd1, 32'h301, 32'h1234, 32'h80FF_7F01,
               1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        dm_txn("e_f3", 1'b0, 3'd3, 32'h300, 32'h0, 32'h80FF_7F01,
               1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);

        // Arbitration with both requests held: DM, DM, IF, DM, DM, IF
        if_req    = 1'b1;
        if_addr   = 32'h0000_0010;
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_funct3 = 3'd2;
        dm_addr   = 32'h300;
        mem_rdata = 32'h0;
        for (int k = 0; k < 6; k++) begin
            seen   = 1'b0;
            got_dm = 1'b0;
            for (int c = 0; c < 5 && !seen; c++) begin
                step();
                if (if_valid || dm_valid) begin
                    seen   = 1'b1;
                    got_dm = dm_valid;
                end
            end
            chk($sformatf("arb.seen%0d", k), 32'(seen), 32'd1);
            chk($sformatf("arb.grant%0d", k), 32'(got_dm), 32'(exp_dm[k]));
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        step();

        // Reset during ACCESS drops the transaction
        dm_req    = 1'b1;
        dm_funct3 = 3'd2;
        dm_addr   = 32'h300;
        step();
        chk("rstacc.en", 32'(mem_en), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rstacc.valid", 32'({if_valid, dm_valid}), 32'd0);
        chk("rstacc.en0", 32'(mem_en), 32'd0);
        rst_n  = 1'b1;
        dm_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rstacc.quiet%0d", i), 32'({if_valid, dm_valid, mem_en}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port synchronous instruction/data BRAM in the RV32I core between the fetch stage and the load/store unit. Data accesses have fixed priority over fetch, with a streak limit against fetch starvation. Performs RV32I byte-lane alignment for stores (SB/SH/SW) and extraction/sign-extension for loads (LB/LH/LW/LBU/LHU). Sits between the core pipeline and the memory instance inside top.

Parameters:
ADDR_W, 12, memory word-address width (4096 words = 16 KiB)
MAX_DM_STREAK, 2, max consecutive data grants while fetch is pending before fetch is forced

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  fetch request, level, held until if_valid
if_addr  in  32  fetch byte address, bits [1:0] ignored
if_rdata  out  32  fetched instruction word
if_valid  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request, level, held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_funct3  in  3  RV32I funct3 (size/sign)
dm_addr  in  32  data byte address
dm_wdata  in  32  store data, LSB-aligned
dm_rdata  out  32  load result, extended to 32 bits
dm_valid  out  1  one-cycle data completion pulse (loads and stores)
dm_err  out  1  with dm_valid: misaligned address or illegal funct3
mem_en  out  1  memory access enable
mem_we  out  4  byte write enables
mem_addr  out  ADDR_W  word address = byte_addr[ADDR_W+1:2]
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read data, valid the cycle after the enabled access

Behaviour:
- Clock is clk; reset is synchronous, active-low, on rst_n.
- Reset: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, dm_valid=0, dm_err=0, if_rdata=0, dm_rdata=0, streak=0. A reset mid-access drops the transaction; no valid pulse follows.
- FSM: IDLE -> ACCESS -> RESP -> IDLE; each state lasts exactly one cycle.
- IDLE (cycle T): grant selection:
  - dm_req && !(if_req && streak==MAX_DM_STREAK) -> grant DM.
  - else if if_req -> grant IF.
  - else stay IDLE.
- Streak counter:
  - DM grant with if_req high increments streak (saturating).
  - DM grant with if_req low clears streak.
  - IF grant clears streak.
- On grant, mem_* registers load and are driven during ACCESS (T+1). Memory samples at end of T+1; mem_rdata is valid in T+2.
- RESP (T+2): the granted valid is high for one cycle with rdata formatted combinationally from mem_rdata. Returns to IDLE at T+3. Requests are not sampled in ACCESS/RESP.
- Requester drops req after its valid; it may re-assert for sampling at T+3. Throughput: 1 access per 3 cycles.
- Outputs not driven by the current transaction:
  - mem_en/mem_we/mem_wdata return to 0 outside ACCESS.
  - if_rdata/dm_rdata are 0 when their valid is low.
  - dm_err is 0 unless dm_valid.
- Fetch: always word read, mem_we=0.
- Stores (dm_we=1), by funct3:
  - 0 SB: we = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - 1 SH: we = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - 2 SW: we = 4'b1111.
  - Any other funct3 is illegal.
  - dm_rdata = 0 on store completion.
- Loads, by funct3; lane selected by addr[1:0]:
  - 0 LB / 4 LBU: sign- / zero-extend the byte.
  - 1 LH / 5 LHU: sign- / zero-extend the half at addr[1].
  - 2 LW: full word.
  - 3, 6, 7 illegal.
- Error: halfword access with addr[0]=1, word access with addr[1:0]!=0, or illegal funct3:
  - no memory access (mem_en stays 0 in ACCESS);
  - RESP still occurs with dm_valid=1, dm_err=1, dm_rdata=0.
- Address bits above ADDR_W+1 are ignored (aliasing).
- Simultaneous if_req and dm_req in IDLE: DM wins unless streak limit reached.

Test Plan:
- Reset: hold rst_n=0 3 cycles with if_req=1 -> all outputs 0, no mem_en. Release -> mem_en=1 one cycle later, if_valid at release+2.
- Fetch: if_addr=0x0000_0104, mem_rdata=0x0010_0093 -> mem_addr=0x041 in ACCESS, if_valid=1 with if_rdata=0x0010_0093 exactly 2 cycles after grant.
- Stores: SB addr 0x203 wdata 0xAB -> mem_we=4'b1000, mem_wdata=0xABABABAB. SH addr 0x202 wdata 0x1234 -> we=4'b1100, wdata=0x12341234. SW addr 0x200 -> we=4'b1111. Each gives dm_valid=1, dm_err=0.
- Loads: mem_rdata=0x80FF7F01 at addr 0x300:
  - LB off1 -> 0x0000007F; LB off3 -> 0xFFFFFF80; LBU off3 -> 0x00000080.
  - LH off2 -> 0xFFFF80FF; LHU off2 -> 0x000080FF.
  - LW -> 0x80FF7F01.
- Errors: LW addr 0x302, SH addr 0x301, funct3=3 -> mem_en stays 0, dm_valid=1, dm_err=1, dm_rdata=0.
- Arbitration: if_req and dm_req held high continuously, MAX_DM_STREAK=2 -> grant order DM, DM, IF, DM, DM, IF. Reset asserted during an ACCESS -> no valid pulse follows.
